// File: rtl/spi_master_mode.sv
// SPI master with per-transfer mode (CPOL/CPHA), slave select and SCK divider.
// Frame: H-cycle lead-in with CS asserted, DATA_W SCK periods, H-cycle tail, then rx_valid.

module spi_master_mode #(
    parameter  int DATA_W = 8,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    half_cnt_q;
    logic [EDGE_W-1:0]   edge_cnt_q;
    logic                cpha_q;
    logic                sck_q;
    logic                mosi_q;
    logic                rx_valid_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [DATA_W-1:0]   rx_data_q;

    logic                half_done_d;
    logic                leading_d;
    logic                last_edge_d;
    logic [NUM_CS-1:0]   cs_dec_d;

    assign half_done_d = (half_cnt_q == div_q);
    // Toggles are counted from zero, so an even count means the next toggle is a leading edge.
    assign leading_d   = ~edge_cnt_q[0];
    assign last_edge_d = (edge_cnt_q == LAST_EDGE);

    // An out-of-range select matches no index and leaves every line deasserted.
    always_comb begin
        // NOTE: default first so every path assigns the vector and no latch is inferred.
        cs_dec_d = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) begin
                cs_dec_d[i] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            cpha_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= '1;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q  <= cpol;
                    mosi_q <= 1'b0;
                    if (start_valid) begin
                        state_q    <= LEAD;
                        div_q      <= clk_div;
                        cpha_q     <= cpha;
                        cs_n_q     <= cs_dec_d;
                        half_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        rx_sh_q    <= '0;
                        // Mode 0 presents the MSB during lead-in; mode 1 waits for the first leading edge.
                        if (cpha) begin
                            tx_sh_q <= tx_data;
                        end else begin
                            mosi_q  <= tx_data[DATA_W-1];
                            tx_sh_q <= {tx_data[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                LEAD: begin
                    if (half_done_d) begin
                        half_cnt_q <= '0;
                        state_q    <= XFER;
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end

                XFER: begin
                    if (half_done_d) begin
                        half_cnt_q <= '0;
                        sck_q      <= ~sck_q;
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                        if (leading_d ^ cpha_q) begin
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
                        end else if (!last_edge_d) begin
                            mosi_q  <= tx_sh_q[DATA_W-1];
                            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                        end
                        if (last_edge_d) begin
                            state_q <= TRAIL;
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end

                TRAIL: begin
                    if (half_done_d) begin
                        half_cnt_q <= '0;
                        state_q    <= IDLE;
                        cs_n_q     <= '1;
                        mosi_q     <= 1'b0;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                    end else begin
                        half_cnt_q <= half_cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with reset keeps the handshake closed during the reset cycle itself.
    assign start_ready = (state_q == IDLE) && !reset;
    assign busy        = (state_q != IDLE);
    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_master_mode.sv
// Bench for spi_master_mode: scoreboard of expected rx words and completion cycles,
// plus per-scenario tasks for reset, SPI modes, abort, out-of-range select and back-to-back.

module tb_spi_master_mode;

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    // Main instance: 8-bit, four selects.
    logic       start_valid, start_ready;
    logic [7:0] tx_data, rx_data;
    logic [1:0] cs_sel;
    logic       cpol, cpha;
    logic [7:0] clk_div;
    logic       rx_valid, busy, sck, mosi, miso;
    logic [3:0] cs_n;

    // Second instance with five selects so index 5 is representable and out of range.
    logic       sv1, sr1, cpol1, cpha1, rxv1, busy1, sck1, mosi1;
    logic [7:0] tx1, rx1, div1;
    logic [2:0] cs1;
    logic [4:0] csn1;

    spi_master_mode #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .tx_data(tx_data), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sck(sck), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    spi_master_mode #(.DATA_W(8), .NUM_CS(5), .DIV_W(8)) dut_oor (
        .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
        .tx_data(tx1), .cs_sel(cs1), .cpol(cpol1), .cpha(cpha1), .clk_div(div1),
        .rx_data(rx1), .rx_valid(rxv1), .busy(busy1), .sck(sck1), .cs_n(csn1),
        .mosi(mosi1), .miso(mosi1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: loads its word when a select goes low, shifts per the configured mode.
    logic       loopback;
    logic [7:0] slv_word;
    logic       slv_cpol, slv_cpha;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_miso = 1'b0;
    logic       sck_prev = 1'b0;
    logic [3:0] cs_prev = 4'hF;

    assign miso = loopback ? mosi : slv_miso;

    always @(negedge clk) begin
        sck_prev <= sck;
        cs_prev  <= cs_n;
        if (!loopback) begin
            if (cs_prev == 4'hF && cs_n != 4'hF) begin
                slv_rx <= 8'h00;
                if (slv_cpha) begin
                    slv_sh <= slv_word;
                end else begin
                    slv_miso <= slv_word[7];
                    slv_sh   <= {slv_word[6:0], 1'b0};
                end
            end else if (cs_n != 4'hF && sck != sck_prev) begin
                if ((sck != slv_cpol) ^ slv_cpha) begin
                    slv_rx <= {slv_rx[6:0], mosi};
                end else begin
                    slv_miso <= slv_sh[7];
                    slv_sh   <= {slv_sh[6:0], 1'b0};
                end
            end
        end
    end

    typedef struct {
        logic [7:0] word;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pend_word;
    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;

    // Observation point: negedge. Pushes on accept, pops and compares on rx_valid.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (rx_valid) begin
                rx_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: rx_valid with data %h at cycle %0d, nothing expected", rx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e.word || cyc !== e.due) begin
                        errors++;
                        $display("FAIL rx_word: got %h at cycle %0d, expected %h at cycle %0d", rx_data, cyc, e.word, e.due);
                    end
                end
            end
            if (start_valid && start_ready) begin
                e.word = pend_word;
                e.due  = cyc + 1 + 18 * (int'(clk_div) + 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Drive point: just after a rising edge.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words pending after %0d cycles, expected 0", exp_q.size(), budget);
        end
    endtask

    // Requests a transfer and returns at the first observation after the accept edge.
    task automatic launch(input logic [7:0] word, input logic [1:0] sel, input logic pol,
                          input logic pha, input logic [7:0] div, input logic [7:0] expect_word,
                          output int acc_cyc);
        bit seen = 1'b0;
        go();
        tx_data = word; cs_sel = sel; cpol = pol; cpha = pha; clk_div = div;
        pend_word = expect_word; start_valid = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = start_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL launch_timeout: start_ready never seen, got 0 expected 1");
        end
        go();
        start_valid = 1'b0;
        step();
        acc_cyc = cyc;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n: got %b expected 1111", cs_n); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", start_ready); end
        checks++; if (csn1 !== 5'h1F) begin errors++; $display("FAIL reset_cs_n_oor: got %b expected 11111", csn1); end
        go();
        reset = 1'b0;
        step();
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", start_ready); end
        go();
        cpol = 1'b1;
        step();
        step();
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL idle_sck_follows_cpol: got %b expected 1", sck); end
        go();
        cpol = 1'b0;
        step();
        step();
    endtask

    task automatic test_mode0_loopback();
        int a;
        launch(8'hA5, 2'd2, 1'b0, 1'b0, 8'd1, 8'hA5, a);
        checks++; if (cs_n !== 4'b1011) begin errors++; $display("FAIL m0_cs_n: got %b expected 1011", cs_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b expected 1", busy); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m0_mosi_msb: got %b expected 1", mosi); end
        checks++; if (sck !== 1'b0) begin errors++; $display("FAIL m0_sck_lead: got %b expected 0", sck); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL m0_ready_busy: got %b expected 0", start_ready); end
        drain(200);
        checks++; if (cs_n !== 4'hF || busy !== 1'b0 || mosi !== 1'b0 || sck !== 1'b0) begin
            errors++;
            $display("FAIL m0_end_state: got cs_n=%b busy=%b mosi=%b sck=%b expected 1111 0 0 0", cs_n, busy, mosi, sck);
        end
        step();
        step();
        checks++; if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL m0_rx_hold: got valid=%b data=%h expected 0 a5", rx_valid, rx_data);
        end
    endtask

    task automatic test_mode3_slave();
        int a;
        go();
        loopback = 1'b0; slv_word = 8'h3C; slv_cpol = 1'b1; slv_cpha = 1'b1; cpol = 1'b1;
        step();
        step();
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_idle_sck: got %b expected 1", sck); end
        launch(8'h08, 2'd0, 1'b1, 1'b1, 8'd0, 8'h3C, a);
        drain(100);
        checks++; if (slv_rx !== 8'h08) begin errors++; $display("FAIL m3_slave_rx: got %h expected 08", slv_rx); end
        checks++; if (sck !== 1'b1) begin errors++; $display("FAIL m3_end_sck: got %b expected 1", sck); end
        go();
        loopback = 1'b1; cpol = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_abort();
        int a;
        int n;
        launch(8'h5A, 2'd1, 1'b0, 1'b0, 8'd1, 8'h5A, a);
        repeat (8) step();
        go();
        reset = 1'b1;
        step();
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset: got %b expected 0", start_ready); end
        go();
        reset = 1'b0;
        step();
        checks++; if (cs_n !== 4'hF || sck !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got cs_n=%b sck=%b busy=%b mosi=%b expected 1111 0 0 0", cs_n, sck, busy, mosi);
        end
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", start_ready); end
        n = rx_cnt;
        repeat (50) step();
        checks++; if (rx_cnt !== n) begin errors++; $display("FAIL abort_no_rx: got %0d pulses expected %0d", rx_cnt, n); end
        launch(8'hC3, 2'd3, 1'b0, 1'b0, 8'd0, 8'hC3, a);
        checks++; if (cs_n !== 4'b0111) begin errors++; $display("FAIL abort_new_cs_n: got %b expected 0111", cs_n); end
        drain(100);
    endtask

    task automatic test_out_of_range();
        bit seen = 1'b0;
        bit got  = 1'b0;
        bit bad  = 1'b0;
        int a1;
        go();
        sv1 = 1'b1; tx1 = 8'h96; cs1 = 3'd5; div1 = 8'd2;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = sr1;
        end
        go();
        sv1 = 1'b0;
        step();
        a1 = cyc;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL oor_busy: got %b expected 1", busy1); end
        for (int i = 0; i < 300 && !got; i++) begin
            if (csn1 !== 5'h1F) bad = 1'b1;
            step();
            got = rxv1;
        end
        checks++; if (bad || csn1 !== 5'h1F) begin errors++; $display("FAIL oor_cs_n: got a low select, last %b expected 11111", csn1); end
        checks++; if (!got) begin errors++; $display("FAIL oor_rx_timeout: got no rx_valid expected one"); end
        checks++; if (cyc - a1 !== 54 || rx1 !== 8'h96) begin
            errors++;
            $display("FAIL oor_rx: got %h after %0d cycles expected 96 after 54", rx1, cyc - a1);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        logic [3:0] prev_cs = 4'hF;
        go();
        tx_data = 8'h02; pend_word = 8'h02; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
        clk_div = 8'd1; start_valid = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = start_ready;
        end
        go();
        tx_data = 8'h06; pend_word = 8'h06;
        step();
        checks++; if (cs_n !== 4'b1110) begin errors++; $display("FAIL b2b_first_cs: got %b expected 1110", cs_n); end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            prev_cs = cs_n;
            step();
            seen = start_ready;
        end
        checks++; if (!seen || rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_on_rx_valid: got ready=%b rx_valid=%b expected 1 1", seen, rx_valid);
        end
        checks++; if (cs_n !== 4'hF || prev_cs !== 4'b1110) begin
            errors++;
            $display("FAIL b2b_gap_edges: got before=%b gap=%b expected 1110 1111", prev_cs, cs_n);
        end
        go();
        start_valid = 1'b0;
        step();
        checks++; if (cs_n !== 4'b1110 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_cs: got cs_n=%b busy=%b expected 1110 1", cs_n, busy);
        end
        drain(200);
    endtask

    task automatic test_config_hold();
        int a;
        int d;
        int ntog = 0;
        int badtog = 0;
        bit done = 1'b0;
        logic [7:0] cap = 8'h00;
        logic ps;
        launch(8'hB4, 2'd1, 1'b0, 1'b0, 8'd2, 8'hB4, a);
        ps = sck;
        for (int i = 0; i < 300 && !done; i++) begin
            if (i == 4) begin
                go();
                cpol = 1'b1; cpha = 1'b1; tx_data = 8'hFF; clk_div = 8'd0;
            end
            step();
            if (rx_valid) begin
                done = 1'b1;
            end else if (sck !== ps) begin
                ntog++;
                d = cyc - a;
                if (d % 3 != 0 || d / 3 < 2 || d / 3 > 17) badtog++;
                if (sck === 1'b1) cap = {cap[6:0], mosi};
            end
            ps = sck;
        end
        checks++; if (!done) begin errors++; $display("FAIL hold_timeout: got no rx_valid expected one"); end
        checks++; if (ntog !== 16 || badtog !== 0) begin
            errors++;
            $display("FAIL hold_sck_timing: got %0d toggles (%0d misplaced) expected 16 (0)", ntog, badtog);
        end
        checks++; if (cap !== 8'hB4) begin errors++; $display("FAIL hold_mosi_bits: got %h expected b4", cap); end
        go();
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; tx_data = 8'h00; cs_sel = 2'd0;
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; pend_word = 8'h00;
        sv1 = 1'b0; tx1 = 8'h00; cs1 = 3'd0; cpol1 = 1'b0; cpha1 = 1'b0; div1 = 8'd0;
        loopback = 1'b1; slv_word = 8'h00; slv_cpol = 1'b0; slv_cpha = 1'b0;
        test_reset();
        test_mode0_loopback();
        test_mode3_slave();
        test_reset_abort();
        test_out_of_range();
        test_back_to_back();
        test_config_hold();
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending words expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
